q3c_x_serializer: RTL and testbench

//   Upstream feeder for the Q3c FSM: accepts parallel words over a valid/ready

---
 rtl/q3c_pkg.sv | 17 +
 rtl/q3c_shift_reg.sv | 31 +++
 rtl/q3c_x_serializer.sv | 118 +++++++++++
 tb/tb_q3c_x_serializer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/q3c_pkg.sv
// Shared types and helpers for the Q3c serial feeder: state encoding and counter sizing.
package q3c_pkg;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_SHIFT = 2'd1,
        SER_PAR   = 2'd2
    } ser_state_t;

    // Counter must hold WIDTH so the parity slot can be indexed past the last data bit.
    function automatic int ser_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int SER_CNT_W = ser_cnt_w(8);

endpackage

// File: rtl/q3c_shift_reg.sv
// Load/shift register for the Q3c serializer; stores the word pre-advanced by one bit
// so next_bit is always the bit to be presented after the one currently on x.
module q3c_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             first_bit,
    output logic             next_bit
);

    logic [WIDTH-1:0] shreg;

    assign first_bit = MSB_FIRST ? data[WIDTH-1] : data[0];
    assign next_bit  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= MSB_FIRST ? {data[WIDTH-2:0], 1'b0} : {1'b0, data[WIDTH-1:1]};
        end else if (shift) begin
            shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/q3c_x_serializer.sv
// Parallel-to-serial feeder driving x into the Q3c FSM over a valid/ready handshake.
// Optional even-parity trailer bit is enabled by defining SER_PARITY_EN.
module q3c_x_serializer
    import q3c_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             x_last,
    output logic             busy
);

    localparam int CNT_W = ser_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    ser_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             x_nxt;
    logic             load, shift, xfer, word_last, ready_int;
    logic             first_bit, next_bit;

    q3c_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .aresetn   (aresetn),
        .load      (load),
        .shift     (shift),
        .data      (in_data),
        .first_bit (first_bit),
        .next_bit  (next_bit)
    );

    assign word_last = (state == SER_SHIFT) && (cnt == LAST_CNT);

`ifdef SER_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= ^in_data;
        end
    end

    assign ready_int = (state == SER_IDLE) || (state == SER_PAR);
    assign x_last    = (state == SER_PAR);
`else
    assign ready_int = (state == SER_IDLE) || word_last;
    assign x_last    = word_last;
`endif

    // Gated by aresetn so the upstream never sees ready while the block is held in reset.
    assign in_ready = ready_int & aresetn;
    assign xfer     = in_valid & in_ready;
    assign busy     = (state != SER_IDLE);
    assign x_valid  = busy;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        x_nxt     = IDLE_BIT;
        load      = 1'b0;
        shift     = 1'b0;
        if (xfer) begin
            state_nxt = SER_SHIFT;
            cnt_nxt   = '0;
            x_nxt     = first_bit;
            load      = 1'b1;
        end else begin
            case (state)
                SER_SHIFT: begin
                    if (word_last) begin
`ifdef SER_PARITY_EN
                        state_nxt = SER_PAR;
                        cnt_nxt   = cnt + 1'b1;
                        x_nxt     = par_q;
`else
                        state_nxt = SER_IDLE;
                        cnt_nxt   = '0;
`endif
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                        x_nxt   = next_bit;
                        shift   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = SER_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= SER_IDLE;
            cnt   <= '0;
            x     <= IDLE_BIT;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            x     <= x_nxt;
        end
    end

endmodule

// File: tb/tb_q3c_x_serializer.sv
// Self-checking bench: two serializers (MSB-first/idle 0, LSB-first/idle 1) driven in lockstep
// and compared every cycle against a queue-of-bits model of the serial stream.
module tb_q3c_x_serializer;

    localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             aresetn = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             rdy_m, x_m, xv_m, xl_m, busy_m;
    logic             rdy_l, x_l, xv_l, xl_l, busy_l;

    int checks = 0;
    int failures = 0;

    // Each entry: {bit, last}; q[0] is the bit currently expected on x.
    logic [1:0] qm[$];
    logic [1:0] ql[$];

    always #5 clk = ~clk;

    q3c_x_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .aresetn(aresetn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .x(x_m), .x_valid(xv_m), .x_last(xl_m), .busy(busy_m)
    );

    q3c_x_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .aresetn(aresetn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .x(x_l), .x_valid(xv_l), .x_last(xl_l), .busy(busy_l)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        for (int k = 0; k < WIDTH; k++) begin
            qm.push_back({d[WIDTH-1-k], (k == WIDTH-1) && !PAR});
            ql.push_back({d[k], (k == WIDTH-1) && !PAR});
        end
        if (PAR) begin
            qm.push_back({^d, 1'b1});
            ql.push_back({^d, 1'b1});
        end
    endtask

    task automatic check_outs(input string tag);
        logic [1:0] hm, hl;
        hm = (qm.size() > 0) ? qm[0] : 2'b00;
        hl = (ql.size() > 0) ? ql[0] : 2'b10;
        chk({tag, ".msb.x"},       x_m,    hm[1]);
        chk({tag, ".msb.x_valid"}, xv_m,   qm.size() > 0);
        chk({tag, ".msb.x_last"},  xl_m,   hm[0]);
        chk({tag, ".msb.busy"},    busy_m, qm.size() > 0);
        chk({tag, ".lsb.x"},       x_l,    hl[1]);
        chk({tag, ".lsb.x_valid"}, xv_l,   ql.size() > 0);
        chk({tag, ".lsb.x_last"},  xl_l,   hl[0]);
    endtask

    // One clock: drive inputs, check ready, update model at the edge, check outputs on negedge.
    task automatic tick(input string tag, input logic v, input logic [WIDTH-1:0] d);
        bit acc;
        in_valid = v;
        in_data  = d;
        #1;
        chk({tag, ".msb.in_ready"}, rdy_m, qm.size() <= 1);
        chk({tag, ".lsb.in_ready"}, rdy_l, ql.size() <= 1);
        acc = v && (qm.size() <= 1);
        @(posedge clk);
        if (qm.size() > 0) void'(qm.pop_front());
        if (ql.size() > 0) void'(ql.pop_front());
        if (acc) push_word(d);
        @(negedge clk);
        check_outs(tag);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".msb.x"},        x_m,   1'b0);
        chk({tag, ".msb.x_valid"},  xv_m,  1'b0);
        chk({tag, ".msb.x_last"},   xl_m,  1'b0);
        chk({tag, ".msb.in_ready"}, rdy_m, 1'b0);
        chk({tag, ".lsb.x"},        x_l,   1'b1);
        chk({tag, ".lsb.x_valid"},  xv_l,  1'b0);
        chk({tag, ".lsb.in_ready"}, rdy_l, 1'b0);
    endtask

    initial begin
        // Reset held with in_valid asserted
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (3) @(negedge clk);
        check_reset("reset");
        aresetn  = 1'b1;
        in_valid = 1'b0;

        tick("idle", 1'b0, 8'h00);
        tick("idle", 1'b0, 8'h00);

        // Single word
        tick("single", 1'b1, 8'hB4);
        repeat (10) tick("single", 1'b0, 8'h00);

        // Back-to-back with in_valid held; data changes while not ready must be ignored
        tick("b2b", 1'b1, 8'hB4);
        repeat (WIDTH + PAR - 1) tick("b2b", 1'b1, 8'h5A);
        tick("b2b", 1'b1, 8'h0F);
        repeat (12) tick("b2b", 1'b0, 8'h00);

        // 0x01: LSB-first gives 1 then zeros
        tick("w01", 1'b1, 8'h01);
        repeat (10) tick("w01", 1'b0, 8'h00);

        // Parity-relevant words (odd and even weight)
        tick("p07", 1'b1, 8'h07);
        repeat (WIDTH + PAR) tick("p03", 1'b1, 8'h03);
        repeat (12) tick("p03", 1'b0, 8'h00);

        // Mid-word reset after three bits
        tick("midrst", 1'b1, 8'hFF);
        tick("midrst", 1'b0, 8'h00);
        tick("midrst", 1'b0, 8'h00);
        #2;
        aresetn = 1'b0;
        #1;
        check_reset("midrst.async");
        qm.delete();
        ql.delete();
        @(negedge clk);
        check_reset("midrst.held");
        aresetn = 1'b1;
        tick("after_rst", 1'b1, 8'h81);
        repeat (11) tick("after_rst", 1'b0, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            tick("rand", ($urandom_range(0, 3) != 0), WIDTH'($urandom));
        end
        repeat (12) tick("drain", 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
